// File: rtl/ladybird_spi_flash_reader_pkg.sv
// ladybird_config: shared constants, FSM state type and byte-order helper for the SPI flash reader
package ladybird_config;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP, GAP} state_t;

    // The flash streams bytes in address order; the first byte received lands in the top byte of the shifter
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ladybird_spi_shifter.sv
// ladybird_spi_shifter: SCK divider, 64-bit bit counter and MOSI/MISO shift registers for one read transfer
module ladybird_spi_shifter
    import ladybird_config::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    input  logic        miso_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [31:0] rx_o
);

    logic        busy_q, busy_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic        half_end;

    // half_end marks the last clk cycle of each SCK half-period
    assign half_end = busy_q && (div_q == 8'(CLK_DIV - 1));
    assign done_o   = half_end && sck_q && (bit_q == 6'd63);
    assign sck_o    = sck_q;
    assign mosi_o   = tx_q[31];
    assign rx_o     = rx_q;

    // Next state: load on start, toggle SCK each half-period, shift out on fall, sample on rise of data bits
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        bit_d  = bit_q;
        sck_d  = sck_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = 8'd0;
            bit_d  = 6'd0;
            sck_d  = 1'b0;
            tx_d   = {SPI_CMD_READ, addr_i};
        end else if (busy_q) begin
            div_d = half_end ? 8'd0 : div_q + 8'd1;
            if (half_end) begin
                sck_d = !sck_q;
                if (sck_q) begin
                    bit_d  = bit_q + 6'd1;
                    tx_d   = {tx_q[30:0], 1'b1};
                    busy_d = (bit_q != 6'd63);
                end else if (bit_q[5]) begin
                    rx_d = {rx_q[30:0], miso_i};
                end
            end
        end
    end

    // State register; ones in tx keep MOSI idle-high outside the command/address phase
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy_q <= 1'b0;
            div_q  <= 8'd0;
            bit_q  <= 6'd0;
            sck_q  <= 1'b0;
            tx_q   <= '1;
            rx_q   <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            sck_q  <= sck_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

endmodule

// File: rtl/ladybird_spi_flash_reader.sv
// ladybird_spi_flash_reader: single-word SPI flash read (cmd 03h) with valid/ready request and response
module ladybird_spi_flash_reader
    import ladybird_config::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_HIGH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic        cs_n_q, cs_n_d;
    logic        resp_valid_q, resp_valid_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        accept, done;
    logic [31:0] rx;

    assign accept     = req_ready_q && req_valid;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign spi_cs_n   = cs_n_q;

    ladybird_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (clk),
        .nrst    (nrst),
        .start_i (accept),
        .addr_i  (req_addr),
        .miso_i  (spi_miso),
        .sck_o   (spi_sck),
        .mosi_o  (spi_mosi),
        .done_o  (done),
        .rx_o    (rx)
    );

    // Next state; registered outputs are derived from the next state so they align with it
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        case (state_q)
            IDLE:  state_d = accept ? SHIFT : IDLE;
            SHIFT: begin
                state_d     = done ? RESP : SHIFT;
                resp_data_d = done ? bswap32(rx) : resp_data_q;
            end
            RESP:  state_d = resp_ready ? GAP : RESP;
            GAP:   state_d = (gap_q >= 8'(CS_HIGH - 1)) ? IDLE : GAP;
        endcase
        gap_d        = (state_q == RESP || state_q == GAP) ? ((gap_q == 8'hFF) ? gap_q : gap_q + 8'd1) : 8'd0;
        cs_n_d       = (state_d != SHIFT);
        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    // State and output registers; gap counts cs_n-high cycles starting at the cs_n rise
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            gap_q        <= 8'd0;
            cs_n_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            cs_n_q       <= cs_n_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_ladybird_spi_flash_reader.sv
// tb_ladybird_spi_flash_reader: scoreboard bench with a behavioural SPI flash on two instances (CLK_DIV 2 and 1)
module tb_ladybird_spi_flash_reader;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][23:0] req_addr = '0;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready = '0;
    logic [1:0][31:0] resp_data;
    logic [1:0]       cs_n, sck, mosi, miso;

    int n_vec = 0;
    int n_err = 0;
    int nresp = 0;
    int cyc = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash contents: byte at address a is (a[7:0]+1)*11h, so 0x100..0x103 read 11 22 33 44
    function automatic logic [7:0] fb(input logic [23:0] a);
        logic [7:0] lo;
        lo = a[7:0] + 8'd1;
        return 8'(lo * 8'h11);
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [31:0] cap = '0;
        int          fcnt = 0;
        int          j;
        logic        mr = 1'b0;
        logic [7:0]  b;

        ladybird_spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : 1), .CS_HIGH(4)) u_dut (
            .clk        (clk),
            .nrst       (nrst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .spi_cs_n   (cs_n[g]),
            .spi_sck    (sck[g]),
            .spi_mosi   (mosi[g]),
            .spi_miso   (miso[g])
        );

        assign miso[g] = mr;

        // Flash front end: count rising SCK edges, capture the first 32 MOSI bits as command+address
        always @(posedge sck[g] or negedge cs_n[g]) begin
            if (!sck[g]) fcnt <= 0;
            else if (!cs_n[g]) begin
                if (fcnt < 32) cap <= {cap[30:0], mosi[g]};
                fcnt <= fcnt + 1;
            end
        end

        // Flash drives read data on falling SCK, MSB-first, auto-incrementing from the captured address
        always @(negedge sck[g]) begin
            if (!cs_n[g] && fcnt >= 32 && fcnt < 64) begin
                j = fcnt - 32;
                b = fb(cap[23:0] + 24'(j / 8));
                mr <= b[7 - (j % 8)];
            end
        end
    end

    // Scoreboard: pop on every response handshake and compare data and the command/address the flash saw
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (nrst && resp_valid[g] && resp_ready[g]) begin
                logic [63:0] e;
                logic [31:0] c;
                nresp++;
                c = (g == 0) ? gi[0].cap : gi[1].cap;
                if (sb_q.size() == 0) chk("resp_pending", 32'(sb_q.size()), 32'd1);
                else begin
                    e = sb_q.pop_front();
                    chk("resp_data", resp_data[g], e[31:0]);
                    chk("mosi_cmd_addr", c, e[63:32]);
                end
            end
        end
    end

    task automatic do_read(input int g, input logic [23:0] a, input int hold, input bit keep, input bit poke);
        int n, lat, r, d, werr, gap;
        logic [63:0] e;
        d = (g == 0) ? 2 : 1;
        e = {8'h03, a, exp_word(a)};
        req_addr[g] = a;
        req_valid[g] = 1'b1;
        n = 0;
        while (!req_ready[g] && n < 1000) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(req_ready[g]), 32'd1);
        sb_q.push_back(e);
        tick();
        if (!keep) req_valid[g] = 1'b0;
        chk("cs_low_after_accept", 32'(cs_n[g]), 32'd0);
        lat = 1;
        werr = 0;
        while (!resp_valid[g] && lat < 2000) begin
            if (sck[g] != (((lat - 1) % (2 * d)) >= d)) werr++;
            if (cs_n[g] || req_ready[g]) werr++;
            if (poke) req_valid[g] = (lat >= 20 && lat < 24);
            tick();
            lat++;
        end
        if (poke) req_valid[g] = 1'b0;
        chk("sck_cs_wave", 32'(werr), 32'd0);
        chk("latency", 32'(lat), 32'(1 + 128 * d));
        r = cyc;
        chk("cs_high_resp", 32'(cs_n[g]), 32'd1);
        chk("sck_low_resp", 32'(sck[g]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(resp_valid[g]), 32'd1);
            chk("hold_data", resp_data[g], e[31:0]);
            chk("hold_not_ready", 32'(req_ready[g]), 32'd0);
        end
        resp_ready[g] = 1'b1;
        tick();
        resp_ready[g] = 1'b0;
        chk("valid_cleared", 32'(resp_valid[g]), 32'd0);
        chk("data_retained", resp_data[g], e[31:0]);
        n = 0;
        while (!req_ready[g] && n < 600) begin
            tick();
            n++;
        end
        gap = (hold + 2 > 4) ? hold + 2 : 4;
        chk("gap_cycles", 32'(cyc - r), 32'(gap));
    endtask

    initial begin
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs_n", 32'(cs_n[g]), 32'd1);
            chk("rst_sck", 32'(sck[g]), 32'd0);
            chk("rst_mosi", 32'(mosi[g]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
            chk("rst_resp_data", resp_data[g], 32'd0);
            chk("rst_req_ready", 32'(req_ready[g]), 32'd0);
        end
        nrst = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready[0]), 32'd1);

        do_read(0, 24'h000100, 10, 1'b0, 1'b0);
        do_read(0, 24'h123457, 0, 1'b1, 1'b0);
        do_read(0, 24'hABCDEF, 0, 1'b0, 1'b0);
        do_read(0, 24'h000203, 3, 1'b0, 1'b1);

        req_addr[0] = 24'h0055AA;
        req_valid[0] = 1'b1;
        chk("accept_ready_rst", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        repeat (161) tick();
        nrst = 1'b0;
        tick();
        chk("midrst_cs_n", 32'(cs_n[0]), 32'd1);
        chk("midrst_sck", 32'(sck[0]), 32'd0);
        chk("midrst_mosi", 32'(mosi[0]), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
        nrst = 1'b1;
        tick();
        chk("ready_after_midrst", 32'(req_ready[0]), 32'd1);
        do_read(0, 24'h000100, 0, 1'b0, 1'b0);

        do_read(1, 24'hFFFFFD, 2, 1'b0, 1'b0);
        do_read(1, 24'h00000A, 0, 1'b0, 1'b0);

        repeat (5) tick();
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        chk("resp_count", 32'(nresp), 32'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
